// File: rtl/vx_tag_assoc_pkg.sv
// Shared definitions for the set-associative tag store: controller states and
// address-split width helpers.
package vx_tag_assoc_pkg;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StIdle  = 2'd1,
        StFlush = 2'd2
    } tag_state_e;

    function automatic int unsigned calc_set_bits(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    // A single-way store still carries a 1-bit way index.
    function automatic int unsigned calc_way_bits(input int unsigned num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/vx_tag_assoc_rr_victim.sv
// Combinational victim selection: lowest-index invalid way, otherwise the
// set's round-robin pointer.
module vx_tag_assoc_rr_victim
    import vx_tag_assoc_pkg::*;
#(
    parameter int unsigned  NUM_WAYS = 4,
    localparam int unsigned WAY_BITS = calc_way_bits(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] i_valid,
    input  logic [WAY_BITS-1:0] i_ptr,
    output logic [WAY_BITS-1:0] o_way
);

    always_comb begin
        o_way = (NUM_WAYS == 1) ? '0 : i_ptr;
        // Descending scan so the lowest invalid way is the last one written.
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_way = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/vx_tag_assoc.sv
// Set-associative tag store with 1-cycle lookup, fill, invalidate and a
// one-set-per-cycle sweep used both after reset and on flush.
module vx_tag_assoc
    import vx_tag_assoc_pkg::*;
#(
    parameter int unsigned  NUM_WAYS  = 4,
    parameter int unsigned  NUM_SETS  = 64,
    parameter int unsigned  TAG_WIDTH = 20,
    localparam int unsigned SET_BITS  = calc_set_bits(NUM_SETS),
    localparam int unsigned WAY_BITS  = calc_way_bits(NUM_WAYS),
    localparam int unsigned ADDR_W    = SET_BITS + TAG_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic                o_ready,
    input  logic                i_lookup_valid,
    input  logic [ADDR_W-1:0]   i_lookup_addr,
    output logic                o_rsp_valid,
    output logic                o_rsp_hit,
    output logic [WAY_BITS-1:0] o_rsp_way,
    output logic                o_rsp_reserved,
    input  logic                i_fill_valid,
    input  logic [ADDR_W-1:0]   i_fill_addr,
    input  logic [WAY_BITS-1:0] i_fill_way,
    input  logic                i_fill_reserve,
    input  logic                i_inval_valid,
    input  logic [ADDR_W-1:0]   i_inval_addr,
    input  logic                i_flush_all,
    output logic                o_flush_done
);

    tag_state_e          r_state, w_state_nxt;
    logic [SET_BITS-1:0] r_idx, w_idx_nxt;

    logic [NUM_WAYS-1:0]  r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]  r_rsvd  [NUM_SETS];
    logic [TAG_WIDTH-1:0] r_tag   [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]  r_ptr   [NUM_SETS];

    logic                r_rsp_valid, r_rsp_hit, r_rsp_rsvd;
    logic [WAY_BITS-1:0] r_rsp_way;

    logic                 w_sweep, w_last;
    logic                 w_lk_en, w_fill_en, w_inv_en;
    logic [SET_BITS-1:0]  w_lk_set, w_fill_set, w_inv_set;
    logic [TAG_WIDTH-1:0] w_lk_tag, w_fill_tag, w_inv_tag;
    logic                 w_hit, w_rsp_rsvd;
    logic [WAY_BITS-1:0]  w_hit_way, w_victim, w_rsp_way, w_ptr_nxt;

    assign w_lk_set   = i_lookup_addr[SET_BITS-1:0];
    assign w_lk_tag   = i_lookup_addr[SET_BITS +: TAG_WIDTH];
    assign w_fill_set = i_fill_addr[SET_BITS-1:0];
    assign w_fill_tag = i_fill_addr[SET_BITS +: TAG_WIDTH];
    assign w_inv_set  = i_inval_addr[SET_BITS-1:0];
    assign w_inv_tag  = i_inval_addr[SET_BITS +: TAG_WIDTH];

    assign o_ready      = (r_state == StIdle);
    assign w_sweep      = (r_state != StIdle);
    assign w_last       = (r_idx == SET_BITS'(NUM_SETS - 1));
    assign o_flush_done = (r_state == StFlush) && w_last;

    // flush_all wins over every other request issued in the same cycle.
    assign w_lk_en   = o_ready && i_lookup_valid && !i_flush_all;
    assign w_fill_en = o_ready && i_fill_valid && !i_flush_all;
    assign w_inv_en  = o_ready && i_inval_valid && !i_flush_all &&
                       !(w_fill_en && (w_fill_set == w_inv_set));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            StInit, StFlush: begin
                w_idx_nxt = r_idx + 1'b1;
                if (w_last) begin
                    w_state_nxt = StIdle;
                    w_idx_nxt   = '0;
                end
            end
            StIdle: begin
                if (i_flush_all) begin
                    w_state_nxt = StFlush;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = StInit;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StInit;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (r_valid[w_lk_set][w] && (r_tag[w_lk_set][w] == w_lk_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
        end
    end

    vx_tag_assoc_rr_victim #(
        .NUM_WAYS(NUM_WAYS)
    ) u_victim (
        .i_valid(r_valid[w_lk_set]),
        .i_ptr  (r_ptr[w_lk_set]),
        .o_way  (w_victim)
    );

    assign w_rsp_way = w_hit ? w_hit_way : w_victim;

    always_comb begin
        w_rsp_rsvd = 1'b0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (WAY_BITS'(w) == w_rsp_way) begin
                w_rsp_rsvd = r_rsvd[w_lk_set][w];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = '0;
        if (NUM_WAYS > 1) begin
            w_ptr_nxt = i_fill_way + 1'b1;
        end
    end

    // Response is captured from pre-write array contents (read-before-write).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_way   <= '0;
            r_rsp_rsvd  <= 1'b0;
        end else begin
            r_rsp_valid <= w_lk_en;
            if (w_lk_en) begin
                r_rsp_hit  <= w_hit;
                r_rsp_way  <= w_rsp_way;
                r_rsp_rsvd <= w_rsp_rsvd;
            end
        end
    end

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_hit      = r_rsp_hit;
    assign o_rsp_way      = r_rsp_way;
    assign o_rsp_reserved = r_rsp_rsvd;

    // Arrays carry no reset; the INIT sweep clears them before ready rises.
    always_ff @(posedge i_clk) begin
        if (w_sweep) begin
            r_valid[r_idx] <= '0;
            r_rsvd[r_idx]  <= '0;
            r_ptr[r_idx]   <= '0;
        end else begin
            if (w_fill_en) begin
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    if (WAY_BITS'(w) == i_fill_way) begin
                        r_valid[w_fill_set][w] <= 1'b1;
                        r_rsvd[w_fill_set][w]  <= i_fill_reserve;
                        r_tag[w_fill_set][w]   <= w_fill_tag;
                    end
                end
                r_ptr[w_fill_set] <= w_ptr_nxt;
            end
            if (w_inv_en) begin
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    if (r_valid[w_inv_set][w] && (r_tag[w_inv_set][w] == w_inv_tag)) begin
                        r_valid[w_inv_set][w] <= 1'b0;
                        r_rsvd[w_inv_set][w]  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_tag_assoc.sv
// Scoreboard bench for vx_tag_assoc with default parameters (4 ways, 64 sets,
// 20-bit tags).
module tb_vx_tag_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        lookup_valid;
    logic [25:0] lookup_addr;
    logic        rsp_valid, rsp_hit, rsp_reserved;
    logic [1:0]  rsp_way;
    logic        fill_valid;
    logic [25:0] fill_addr;
    logic [1:0]  fill_way;
    logic        fill_reserve;
    logic        inval_valid;
    logic [25:0] inval_addr;
    logic        flush_all;
    logic        flush_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       hit;
        logic [1:0] way;
        logic       rsv;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vx_tag_assoc dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .o_ready       (ready),
        .i_lookup_valid(lookup_valid),
        .i_lookup_addr (lookup_addr),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_hit     (rsp_hit),
        .o_rsp_way     (rsp_way),
        .o_rsp_reserved(rsp_reserved),
        .i_fill_valid  (fill_valid),
        .i_fill_addr   (fill_addr),
        .i_fill_way    (fill_way),
        .i_fill_reserve(fill_reserve),
        .i_inval_valid (inval_valid),
        .i_inval_addr  (inval_addr),
        .i_flush_all   (flush_all),
        .o_flush_done  (flush_done)
    );

    function automatic logic [25:0] mk(input logic [19:0] tag, input logic [5:0] set);
        return {tag, set};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        lookup_valid = 1'b0; lookup_addr = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_way = '0; fill_reserve = 1'b0;
        inval_valid = 1'b0; inval_addr = '0;
        flush_all = 1'b0;
    endtask

    task automatic do_fill(input logic [25:0] a, input logic [1:0] w, input logic r);
        fill_valid = 1'b1; fill_addr = a; fill_way = w; fill_reserve = r;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic test_reset();
        int   cycles;
        exp_t e;
        clr_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({ready, rsp_valid, rsp_hit, rsp_way, rsp_reserved, flush_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0000000",
                     {ready, rsp_valid, rsp_hit, rsp_way, rsp_reserved, flush_done});
        end
        rst_n  = 1'b1;
        cycles = 0;
        while (!ready && cycles < 200) begin
            tick();
            cycles++;
        end
        n_checks++;
        if (cycles !== 64) begin
            n_fail++;
            $display("FAIL init_sweep_len: got %0d cycles, want 64", cycles);
        end
        lookup_valid = 1'b1; lookup_addr = mk(20'h12345, 6'd0);
        sb.push_back({1'b0, 2'd0, 1'b0});
        tick();
        lookup_valid = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL reset_first_lookup: got %b, want %b",
                     {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
        end
    endtask

    task automatic test_fill_hit();
        logic [25:0] la [3];
        exp_t        le [3];
        exp_t        e;
        do_fill(mk(20'hABCDE, 6'd5), 2'd2, 1'b1);
        la = '{mk(20'hABCDE, 6'd5), mk(20'hABCDE, 6'd6), mk(20'hABCDF, 6'd5)};
        le = '{{1'b1, 2'd2, 1'b1}, {1'b0, 2'd0, 1'b0}, {1'b0, 2'd0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            lookup_valid = 1'b1; lookup_addr = la[i];
            sb.push_back(le[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL fill_hit[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [25:0] la [5];
        exp_t        le [5];
        exp_t        e;
        do_fill(mk(20'h90, 6'd9), 2'd0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            do_fill(mk(20'h100 + 20'(w), 6'd7), 2'(w), 1'b0);
        end
        la = '{mk(20'h91, 6'd9), mk(20'h200, 6'd7), mk(20'h102, 6'd7), '0, '0};
        le = '{{1'b0, 2'd1, 1'b0}, {1'b0, 2'd0, 1'b0}, {1'b1, 2'd2, 1'b0}, '0, '0};
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                lookup_valid = 1'b0;
                do_fill(mk(20'h200, 6'd7), 2'd0, 1'b0);
                la[3] = mk(20'h300, 6'd7); le[3] = {1'b0, 2'd1, 1'b0};
                la[4] = mk(20'h100, 6'd7); le[4] = {1'b0, 2'd1, 1'b0};
            end
            lookup_valid = 1'b1; lookup_addr = la[i];
            sb.push_back(le[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
        lookup_valid = 1'b0;
        // Pointer lands on a reserved, valid way: miss reports its reserved bit.
        do_fill(mk(20'h101, 6'd7), 2'd1, 1'b1);
        do_fill(mk(20'h200, 6'd7), 2'd0, 1'b0);
        lookup_valid = 1'b1; lookup_addr = mk(20'h300, 6'd7);
        sb.push_back({1'b0, 2'd1, 1'b1});
        tick();
        lookup_valid = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL victim_reserved: got %b, want %b",
                     {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
        end
    endtask

    task automatic test_inval();
        logic [25:0] la [7];
        exp_t        le [7];
        exp_t        e;
        // set 7: w0=0x200 w1=0x101(r) w2=0x102 w3=0x103, ptr=1
        la = '{mk(20'h101, 6'd7), mk(20'h102, 6'd7), mk(20'h102, 6'd7), mk(20'h400, 6'd7),
               mk(20'h500, 6'd7), mk(20'h10, 6'd11), mk(20'h103, 6'd7)};
        le = '{{1'b0, 2'd1, 1'b0}, {1'b1, 2'd2, 1'b0}, {1'b1, 2'd2, 1'b0}, {1'b1, 2'd1, 1'b0},
               {1'b0, 2'd2, 1'b0}, {1'b1, 2'd0, 1'b0}, {1'b0, 2'd3, 1'b0}};
        for (int i = 0; i < 7; i++) begin
            lookup_valid = 1'b0;
            if (i == 0) begin
                inval_valid = 1'b1; inval_addr = mk(20'h101, 6'd7);
                tick();
            end else if (i == 1) begin
                inval_valid = 1'b1; inval_addr = mk(20'h999, 6'd7);
                tick();
            end else if (i == 2) begin
                fill_valid = 1'b1; fill_addr = mk(20'h400, 6'd7); fill_way = 2'd1;
                fill_reserve = 1'b0;
                inval_valid = 1'b1; inval_addr = mk(20'h102, 6'd7);
                tick();
            end else if (i == 5) begin
                fill_valid = 1'b1; fill_addr = mk(20'h10, 6'd11); fill_way = 2'd0;
                fill_reserve = 1'b0;
                inval_valid = 1'b1; inval_addr = mk(20'h103, 6'd7);
                tick();
            end
            fill_valid = 1'b0; inval_valid = 1'b0;
            lookup_valid = 1'b1; lookup_addr = la[i];
            sb.push_back(le[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL inval[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_read_before_write();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                fill_valid = 1'b1; fill_addr = mk(20'h555, 6'd20); fill_way = 2'd3;
                fill_reserve = 1'b1;
                sb.push_back({1'b0, 2'd0, 1'b0});
            end else begin
                sb.push_back({1'b1, 2'd3, 1'b1});
            end
            lookup_valid = 1'b1; lookup_addr = mk(20'h555, 6'd20);
            tick();
            fill_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL read_before_write[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [25:0] la [4];
        exp_t        le [4];
        exp_t        e;
        do_fill(mk(20'hA0, 6'd40), 2'd0, 1'b0);
        do_fill(mk(20'hA1, 6'd40), 2'd1, 1'b0);
        la = '{mk(20'hA0, 6'd40), mk(20'hA1, 6'd40), mk(20'hA2, 6'd40), mk(20'hA0, 6'd40)};
        le = '{{1'b1, 2'd0, 1'b0}, {1'b1, 2'd1, 1'b0}, {1'b0, 2'd2, 1'b0}, {1'b1, 2'd0, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            lookup_valid = 1'b1; lookup_addr = la[i];
            sb.push_back(le[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
        lookup_valid = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rsp_valid: got %b, want 0", rsp_valid);
        end
    endtask

    task automatic test_flush();
        int          cycles, pulses, seen_rsp;
        logic [25:0] la [5];
        exp_t        e;
        flush_all = 1'b1; lookup_valid = 1'b1; lookup_addr = mk(20'hABCDE, 6'd5);
        tick();
        flush_all = 1'b0;
        n_checks++;
        if ({rsp_valid, ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_drops_lookup: got valid/ready=%b, want 00", {rsp_valid, ready});
        end
        cycles = 0; pulses = 0; seen_rsp = 0;
        while (!ready && cycles < 200) begin
            if (flush_done) pulses++;
            if (rsp_valid) seen_rsp++;
            // Requests while busy, including a fill to an already-swept set.
            if (cycles == 10) begin
                fill_valid = 1'b1; fill_addr = mk(20'h77, 6'd2); fill_way = 2'd1;
                flush_all = 1'b1;
            end else if (cycles == 11) begin
                fill_valid = 1'b0; flush_all = 1'b0;
            end
            tick();
            cycles++;
        end
        lookup_valid = 1'b0;
        n_checks++;
        if (cycles !== 64 || pulses !== 1 || seen_rsp !== 0) begin
            n_fail++;
            $display("FAIL flush_sweep: got cycles=%0d pulses=%0d rsp=%0d, want 64 1 0",
                     cycles, pulses, seen_rsp);
        end
        la = '{mk(20'hABCDE, 6'd5), mk(20'h200, 6'd7), mk(20'h555, 6'd20), mk(20'h77, 6'd2),
               mk(20'h10, 6'd11)};
        for (int i = 0; i < 5; i++) begin
            lookup_valid = 1'b1; lookup_addr = la[i];
            sb.push_back({1'b0, 2'd0, 1'b0});
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL after_flush[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
        lookup_valid = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        int   cycles, pulses;
        exp_t e;
        do_fill(mk(20'h33, 6'd3), 2'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                flush_all = 1'b1;
                tick();
                flush_all = 1'b0;
                pulses = 0;
                repeat (30) begin
                    if (flush_done) pulses++;
                    tick();
                end
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({ready, rsp_valid, rsp_hit, rsp_way, rsp_reserved, flush_done} !== 7'b0) begin
                    n_fail++;
                    $display("FAIL mid_flush_reset_outputs: got %b, want 0000000",
                             {ready, rsp_valid, rsp_hit, rsp_way, rsp_reserved, flush_done});
                end
                tick();
                tick();
                rst_n  = 1'b1;
                cycles = 0;
                while (!ready && cycles < 200) begin
                    if (flush_done) pulses++;
                    tick();
                    cycles++;
                end
                n_checks++;
                if (cycles !== 64 || pulses !== 0) begin
                    n_fail++;
                    $display("FAIL mid_flush_reset: got cycles=%0d pulses=%0d, want 64 0",
                             cycles, pulses);
                end
                sb.push_back({1'b0, 2'd0, 1'b0});
            end else begin
                sb.push_back({1'b1, 2'd1, 1'b0});
            end
            lookup_valid = 1'b1; lookup_addr = mk(20'h33, 6'd3);
            tick();
            lookup_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_hit, rsp_way, rsp_reserved} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL mid_flush_lookup[%0d]: got %b, want %b", i,
                         {rsp_valid, rsp_hit, rsp_way, rsp_reserved}, {1'b1, e});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        test_reset();
        test_fill_hit();
        test_round_robin();
        test_inval();
        test_read_before_write();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_tag_assoc.md
VX_TAG_ASSOC -- requirements
Module: VX_tag_assoc

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, ways per set; power of two, 1..8.
REQ-002 SHALL have parameter NUM_SETS, default 64, sets per bank; power of two, >=2.
REQ-003 SHALL have parameter TAG_WIDTH, default 20, stored tag bits; SET_BITS=log2(NUM_SETS), WAY_BITS=max(1,log2(NUM_WAYS)).
REQ-004 SHALL have the ports below. One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ready  out  1  high only in IDLE; requests accepted only while high.
REQ-008 lookup_valid  in  1; lookup_addr  in  SET_BITS+TAG_WIDTH  line address, set = low SET_BITS, tag = upper bits.
REQ-009 rsp_valid  out  1; rsp_hit  out  1; rsp_way  out  WAY_BITS (hit way, else victim way); rsp_reserved  out  1 (reserved bit of rsp_way).
REQ-010 fill_valid  in  1; fill_addr  in  SET_BITS+TAG_WIDTH; fill_way  in  WAY_BITS; fill_reserve  in  1.
REQ-011 inval_valid  in  1; inval_addr  in  SET_BITS+TAG_WIDTH  invalidate matching line.
REQ-012 flush_all  in  1  request full invalidation; flush_done  out  1  one-cycle completion pulse.

Function
REQ-013 States: INIT, IDLE, FLUSH; INIT->IDLE and FLUSH->IDLE after sweep of set NUM_SETS-1; IDLE->FLUSH on flush_all.
REQ-014 Sweep: one set per cycle, index 0..NUM_SETS-1; clears valid, reserved and replacement pointer for all ways; exactly NUM_SETS cycles.
REQ-015 Per way per set: valid bit, reserved bit, tag; per set: WAY_BITS round-robin pointer.
REQ-016 Lookup latency exactly 1 cycle: rsp_valid high the cycle after an accepted lookup, low otherwise.
REQ-017 rsp_hit=1 iff one valid way tag equals lookup tag; rsp_way = that way.
REQ-018 On miss: rsp_way = lowest-index invalid way; if all valid, the set's pointer value.
REQ-019 Fill writes valid=1, tag, reserved=fill_reserve into (set, fill_way); pointer becomes (fill_way+1) mod NUM_WAYS.
REQ-020 Invalidate clears valid and reserved of the matching way only; no match -> no change; pointer unchanged.
REQ-021 Same-cycle fill and inval to same set: fill applied, inval dropped; different sets: both applied.
REQ-022 Lookup concurrent with fill/inval on same set returns pre-write contents (read-before-write).
REQ-023 flush_all in IDLE takes priority: same-cycle lookup/fill/inval dropped, rsp_valid next cycle = 0.
REQ-024 All inputs ignored while ready=0 (including flush_all); no queuing.
REQ-025 flush_done pulses in cycle FLUSH->IDLE; never after INIT.
REQ-026 NUM_WAYS=1: rsp_way always 0, pointer constant 0.

Reset
REQ-027 On reset assertion: state=INIT, sweep index=0, ready=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_reserved=0, flush_done=0.
REQ-028 Reset mid-FLUSH aborts; flush_done not pulsed; INIT sweep restarts from set 0.
REQ-029 Reset release is synchronised internally; first INIT sweep cycle is the first rising edge after deassertion.

Structure
REQ-030 State enum, SET_BITS/WAY_BITS derivation and the line-address tag/set split macros SHALL live in the shared cache define package.
REQ-031 One sub-module, VX_rr_victim_sel: combinational victim select from valid vector and pointer; tag/valid arrays held in flops inside VX_tag_assoc.

Verification
REQ-032 Reset release, NUM_SETS=64 -> ready=0 for 64 cycles, ready=1 at cycle 65, any lookup misses with rsp_way=0.
REQ-033 Fill set 5 way 2 tag 0xABCDE reserve=1; lookup same addr -> next cycle rsp_hit=1, rsp_way=2, rsp_reserved=1.
REQ-034 Fill ways 0..3 of set 7, lookup new tag -> rsp_hit=0, rsp_way=0 (pointer wrapped); fill way 0 -> next miss rsp_way=1.
REQ-035 Lookup and fill same address same cycle -> rsp_hit=0; repeat lookup -> rsp_hit=1.
REQ-036 flush_all with lookup same cycle -> rsp_valid=0, ready=0 for 64 cycles, flush_done one pulse, all prior tags miss.
REQ-037 Reset asserted at flush sweep index 30 -> no flush_done, full 64-cycle INIT, all lines invalid.
